// File: rtl/addsub_pkg.sv
// addsub_pkg: shared state type for the chunked adder/subtractor
package addsub_pkg;
    typedef enum logic [1:0] {IDLE, RUN, DONE} addsub_state_t;
endpackage

// File: rtl/rca_nbit.sv
// rca_nbit: combinational N-bit ripple-carry adder built from full-adder cells
module rca_nbit #(
    parameter int N = 4
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic [N-1:0] s,
    output logic         cout
);
    logic [N:0] c;
    assign c[0] = cin;
    for (genvar i = 0; i < N; i++) begin : g_fa
        assign s[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
    assign cout = c[N];
endmodule

// File: rtl/chunked_addsub_seq.sv
// chunked_addsub_seq: multi-cycle add/sub, CHUNK bits per cycle through one shared ripple adder
module chunked_addsub_seq
    import addsub_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);
    localparam int CSAFE  = CHUNK < 1 ? 1 : CHUNK;
    localparam int NCHUNK = WIDTH / CSAFE;
    localparam int CW     = NCHUNK > 1 ? $clog2(NCHUNK) : 1;

    if (CHUNK < 1 || WIDTH % CSAFE != 0) begin : g_bad_param
        $error("chunked_addsub_seq: CHUNK must be >= 1 and divide WIDTH");
    end

    addsub_state_t    state, state_nx;
    logic [CW-1:0]    cnt;
    logic             carry;
    logic [WIDTH-1:0] a_q, bx_q, sum_nx;
    logic [CHUNK-1:0] s_c;
    logic             c_c, last;

    rca_nbit #(.N(CHUNK)) u_rca (
        .a   (a_q[cnt*CHUNK +: CHUNK]),
        .b   (bx_q[cnt*CHUNK +: CHUNK]),
        .cin (carry),
        .s   (s_c),
        .cout(c_c)
    );

    assign last      = cnt == CW'(NCHUNK - 1);
    assign in_ready  = state == IDLE;
    assign out_valid = state == DONE;

    always_comb begin
        sum_nx = sum;
        sum_nx[cnt*CHUNK +: CHUNK] = s_c;
        state_nx = state == IDLE ? (in_valid ? RUN : IDLE) :
                   state == RUN  ? (last ? DONE : RUN) :
                   (out_ready ? IDLE : DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // Subtract is folded into the operands: B is inverted and the +1 enters as the initial carry
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q   <= '0;
            bx_q  <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
            zero  <= 1'b0;
        end else if (state == IDLE && in_valid) begin
            a_q   <= a;
            bx_q  <= b ^ {WIDTH{sub}};
            carry <= sub;
            cnt   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
            zero  <= 1'b0;
        end else if (state == RUN) begin
            sum   <= sum_nx;
            carry <= c_c;
            cnt   <= cnt + 1'b1;
            if (last) begin
                cout <= c_c;
                ovf  <= (a_q[WIDTH-1] == bx_q[WIDTH-1]) && (s_c[CHUNK-1] != a_q[WIDTH-1]);
                zero <= sum_nx == '0;
            end
        end
    end
endmodule

// File: tb/tb_chunked_addsub_seq.sv
// tb_chunked_addsub_seq: directed and random checks of three CHUNK configurations against an arithmetic model
module tb_chunked_addsub_seq;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        iv[3], ordy[3], isub[3];
    logic [15:0] ia[3], ib[3];
    logic        ir[3], ov[3], co[3], vf[3], zr[3];
    logic [15:0] so[3];
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    chunked_addsub_seq #(.WIDTH(16), .CHUNK(4)) u_c4 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]), .a(ia[0]), .b(ib[0]),
        .sub(isub[0]), .out_valid(ov[0]), .out_ready(ordy[0]), .sum(so[0]), .cout(co[0]),
        .ovf(vf[0]), .zero(zr[0]));
    chunked_addsub_seq #(.WIDTH(16), .CHUNK(16)) u_c16 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]), .a(ia[1]), .b(ib[1]),
        .sub(isub[1]), .out_valid(ov[1]), .out_ready(ordy[1]), .sum(so[1]), .cout(co[1]),
        .ovf(vf[1]), .zero(zr[1]));
    chunked_addsub_seq #(.WIDTH(16), .CHUNK(1)) u_c1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir[2]), .a(ia[2]), .b(ib[2]),
        .sub(isub[2]), .out_valid(ov[2]), .out_ready(ordy[2]), .sum(so[2]), .cout(co[2]),
        .ovf(vf[2]), .zero(zr[2]));

    function automatic int lat(input int k);
        return k == 0 ? 4 : k == 1 ? 1 : 16;
    endfunction

    // {cout, ovf, zero, sum} from integer arithmetic on the operands
    function automatic logic [18:0] model(input logic [15:0] x, input logic [15:0] y, input logic s);
        int          sx = int'($signed(x));
        int          sy = int'($signed(y));
        int          r  = s ? sx - sy : sx + sy;
        logic [15:0] q  = 16'(r);
        logic [16:0] t  = {1'b0, x} + {1'b0, y};
        logic        c  = s ? (x >= y) : t[16];
        logic        v  = (r > 32767) || (r < -32768);
        return {c, v, q == 16'h0, q};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input int k, input string tag, input logic [18:0] e);
        chk({tag, "_sum"}, 32'(so[k]), 32'(e[15:0]));
        chk({tag, "_zero"}, 32'(zr[k]), 32'(e[16]));
        chk({tag, "_ovf"}, 32'(vf[k]), 32'(e[17]));
        chk({tag, "_cout"}, 32'(co[k]), 32'(e[18]));
    endtask

    task automatic start(input int k, input logic [15:0] x, input logic [15:0] y, input logic s);
        int t = 0;
        while (!ir[k] && t < 100) begin
            @(posedge clk);
            @(negedge clk);
            t++;
        end
        chk("accept_ready", 32'(ir[k]), 32'(1));
        iv[k]   = 1'b1;
        ia[k]   = x;
        ib[k]   = y;
        isub[k] = s;
        @(posedge clk);
        @(negedge clk);
        iv[k] = 1'b0;
    endtask

    task automatic result(input int k, input logic [15:0] x, input logic [15:0] y, input logic s);
        int n = 0;
        while (!ov[k] && n < 100) begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end
        chk("latency", 32'(n), 32'(lat(k)));
        chk_out(k, "res", model(x, y, s));
        chk("in_ready_done", 32'(ir[k]), 32'(0));
    endtask

    task automatic release_out(input int k);
        ordy[k] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        ordy[k] = 1'b0;
        chk("in_ready_after", 32'(ir[k]), 32'(1));
        chk("out_valid_after", 32'(ov[k]), 32'(0));
    endtask

    task automatic op(input int k, input logic [15:0] x, input logic [15:0] y, input logic s);
        start(k, x, y, s);
        result(k, x, y, s);
        release_out(k);
    endtask

    initial begin
        logic [18:0] e;
        logic [15:0] x, y;
        logic        s;
        rst_n = 1'b0;
        for (int k = 0; k < 3; k++) begin
            iv[k] = 1'b0; ordy[k] = 1'b0; isub[k] = 1'b0; ia[k] = '0; ib[k] = '0;
        end
        @(negedge clk);
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            chk_out(k, "reset", 19'h0);
            chk("reset_out_valid", 32'(ov[k]), 32'(0));
            chk("reset_in_ready", 32'(ir[k]), 32'(1));
        end
        rst_n = 1'b1;
        @(negedge clk);

        op(0, 16'h1234, 16'h4321, 1'b0);
        op(0, 16'hFFFF, 16'h0001, 1'b0);
        op(0, 16'h0005, 16'h0007, 1'b1);
        op(0, 16'h8000, 16'h0001, 1'b1);
        op(0, 16'h7FFF, 16'h0001, 1'b0);

        start(0, 16'hA5A5, 16'h0F0F, 1'b0);
        result(0, 16'hA5A5, 16'h0F0F, 1'b0);
        e = model(16'hA5A5, 16'h0F0F, 1'b0);
        for (int i = 0; i < 3; i++) begin
            iv[0] = ~iv[0];
            ia[0] = 16'($urandom);
            ib[0] = 16'($urandom);
            @(posedge clk);
            @(negedge clk);
            chk_out(0, "hold", e);
            chk("hold_out_valid", 32'(ov[0]), 32'(1));
            chk("hold_in_ready", 32'(ir[0]), 32'(0));
        end
        iv[0] = 1'b0;
        release_out(0);
        op(0, 16'h1111, 16'h2222, 1'b1);

        start(0, 16'h1234, 16'h5678, 1'b0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #2;
        chk_out(0, "abort", 19'h0);
        chk("abort_out_valid", 32'(ov[0]), 32'(0));
        chk("abort_in_ready", 32'(ir[0]), 32'(1));
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("abort_no_result", 32'(ov[0]), 32'(0));
        end
        op(0, 16'h0001, 16'h0001, 1'b0);

        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 1000; i++) begin
                x = 16'($urandom);
                y = 16'($urandom);
                s = 1'($urandom);
                if (i % 8 == 0) y = s ? x : 16'(~x + 16'h1);
                if (i % 8 == 1) y = s ? 16'(x ^ 16'h8000) : 16'(16'h8000 - x);
                op(k, x, y, s);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
